// File: rtl/de_regfile_scoreboard_pkg.sv
// Shared definitions for the decode-stage register file and scoreboard.
// Holds the datapath widths, the CSR address map, the packed WB->DE bus
// layout and a small CSR address decoder used by both read and write paths.
package de_regfile_scoreboard_pkg;

  localparam int unsigned DBITS     = 32;
  localparam int unsigned REGNOBITS = 5;
  localparam int unsigned REGWORDS  = 32;
  localparam int unsigned CSRNOBITS = 12;
  localparam int unsigned SBBITS    = 2;

  // Width of the packed WB->DE bus.
  localparam int unsigned WB_TO_DE_BITS = 1 + REGNOBITS + DBITS + CSRNOBITS + 1;

  localparam logic [CSRNOBITS-1:0] CSR_MSTATUS = 12'h300;
  localparam logic [CSRNOBITS-1:0] CSR_MTVEC   = 12'h305;
  localparam logic [CSRNOBITS-1:0] CSR_MEPC    = 12'h341;
  localparam logic [CSRNOBITS-1:0] CSR_MCAUSE  = 12'h342;

  localparam int unsigned NUM_CSRS = 4;

  // Field order of from_WB_to_DE, MSB first.
  typedef struct packed {
    logic                 wr_reg;
    logic [REGNOBITS-1:0] wregno;
    logic [DBITS-1:0]     regval;
    logic [CSRNOBITS-1:0] wcsrno;
    logic                 wr_csr;
  } wb_to_de_t;

  // One-hot select over {mcause, mepc, mtvec, mstatus}; all-zero when unmapped.
  function automatic logic [NUM_CSRS-1:0] csr_onehot(input logic [CSRNOBITS-1:0] addr);
    logic [NUM_CSRS-1:0] sel;
    sel    = '0;
    sel[0] = (addr == CSR_MSTATUS);
    sel[1] = (addr == CSR_MTVEC);
    sel[2] = (addr == CSR_MEPC);
    sel[3] = (addr == CSR_MCAUSE);
    return sel;
  endfunction

endpackage

// File: rtl/regfile_sb_counter.sv
// Saturating up/down pending-writer counter for one register.
// Ports: clk, reset (async, active-high), inc, dec, cnt (current count),
// overflow / underflow (single-cycle pulses when an inc/dec is refused).
module regfile_sb_counter
  import de_regfile_scoreboard_pkg::*;
#(
  parameter int unsigned Bits = SBBITS
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inc,
  input  logic            dec,
  output logic [Bits-1:0] cnt,
  output logic            overflow,
  output logic            underflow
);

  localparam logic [Bits-1:0] CntMax = '1;

  logic [Bits-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d     = cnt_q;
    overflow  = 1'b0;
    underflow = 1'b0;
    // Simultaneous inc and dec cancel out.
    if (inc && !dec) begin
      if (cnt_q == CntMax) overflow = 1'b1;
      else                 cnt_d    = cnt_q + Bits'(1);
    end else if (dec && !inc) begin
      if (cnt_q == '0) underflow = 1'b1;
      else             cnt_d     = cnt_q - Bits'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/de_regfile_scoreboard.sv
// Decode-stage write/commit end of the writeback interface.
// Holds the 32-entry integer register file and a 4-entry CSR bank, serves two
// register read ports and one CSR read port with same-cycle WB bypass, and
// tracks pending writers per register to produce stall_de.
// Ports: clk, reset (async, active-high), from_WB_to_DE (packed WB bus),
// rs1/rs2 read address/used/data, csr_rno/csr_rval, issue_* (DE issue info),
// stall_de, sticky sb_overflow/sb_underflow, reg10_val (registered x10).
module de_regfile_scoreboard
  import de_regfile_scoreboard_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WB_TO_DE_BITS-1:0] from_WB_to_DE,
  input  logic [REGNOBITS-1:0]     rs1_no,
  input  logic [REGNOBITS-1:0]     rs2_no,
  input  logic                     rs1_used,
  input  logic                     rs2_used,
  output logic [DBITS-1:0]         rs1_val,
  output logic [DBITS-1:0]         rs2_val,
  input  logic [CSRNOBITS-1:0]     csr_rno,
  output logic [DBITS-1:0]         csr_rval,
  input  logic                     issue_valid,
  input  logic                     issue_wr_reg,
  input  logic [REGNOBITS-1:0]     issue_wregno,
  output logic                     stall_de,
  output logic                     sb_overflow,
  output logic                     sb_underflow,
  output logic [DBITS-1:0]         reg10_val
);

  wb_to_de_t wb;
  assign wb = from_WB_to_DE;

  logic we;
  assign we = wb.wr_reg && (wb.wregno != '0);

  logic [DBITS-1:0] regs_q [REGWORDS];
  logic [DBITS-1:0] csr_q  [NUM_CSRS];

  logic [NUM_CSRS-1:0] csr_wsel, csr_rsel;
  assign csr_wsel = csr_onehot(wb.wcsrno);
  assign csr_rsel = csr_onehot(csr_rno);

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REGWORDS; i++) regs_q[i] <= '0;
      for (int i = 0; i < NUM_CSRS; i++) csr_q[i] <= '0;
    end else begin
      if (we) regs_q[wb.wregno] <= wb.regval;
      if (wb.wr_csr) begin
        for (int i = 0; i < NUM_CSRS; i++) begin
          if (csr_wsel[i]) csr_q[i] <= wb.regval;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports with WB bypass
  // ---------------------------------------------------------------------------
  always_comb begin
    rs1_val = regs_q[rs1_no];
    if (rs1_no == '0)                   rs1_val = '0;
    else if (we && wb.wregno == rs1_no) rs1_val = wb.regval;

    rs2_val = regs_q[rs2_no];
    if (rs2_no == '0)                   rs2_val = '0;
    else if (we && wb.wregno == rs2_no) rs2_val = wb.regval;

    csr_rval = '0;
    for (int i = 0; i < NUM_CSRS; i++) begin
      if (csr_rsel[i]) csr_rval = csr_q[i];
    end
    // Unmapped addresses decode to zero select, so bypass is only taken for mapped CSRs.
    if (wb.wr_csr && (wb.wcsrno == csr_rno) && (csr_rsel != '0)) csr_rval = wb.regval;
  end

  assign reg10_val = regs_q[10];

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [REGWORDS-1:1] inc_vec, dec_vec, ovf_vec, udf_vec;
  logic [SBBITS-1:0]   cnt [REGWORDS];

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (issue_valid && issue_wr_reg && (issue_wregno != '0)) inc_vec[issue_wregno] = 1'b1;
    if (we) dec_vec[wb.wregno] = 1'b1;
  end

  assign cnt[0] = '0;

  for (genvar g = 1; g < REGWORDS; g++) begin : g_cnt
    regfile_sb_counter #(
      .Bits(SBBITS)
    ) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .inc      (inc_vec[g]),
      .dec      (dec_vec[g]),
      .cnt      (cnt[g]),
      .overflow (ovf_vec[g]),
      .underflow(udf_vec[g])
    );
  end

  // A last pending write arriving this cycle is covered by the bypass.
  logic busy1, busy2;
  always_comb begin
    busy1 = (cnt[rs1_no] > SBBITS'(1)) ||
            ((cnt[rs1_no] == SBBITS'(1)) && !(we && wb.wregno == rs1_no));
    busy2 = (cnt[rs2_no] > SBBITS'(1)) ||
            ((cnt[rs2_no] == SBBITS'(1)) && !(we && wb.wregno == rs2_no));
  end

  assign stall_de = (rs1_used && busy1) || (rs2_used && busy2);

  logic ovf_q, udf_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | (|ovf_vec);
      udf_q <= udf_q | (|udf_vec);
    end
  end

  assign sb_overflow  = ovf_q;
  assign sb_underflow = udf_q;

endmodule

// File: tb/tb_de_regfile_scoreboard.sv
// Scoreboard bench: each stimulus cycle pushes the expected outputs (from a
// behavioural model of the register file, CSRs and pending-write counts) into
// a queue; a monitor on the falling edge pops and compares.
module tb_de_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_reg, wr_csr;
  logic [4:0]  wregno;
  logic [31:0] regval;
  logic [11:0] wcsrno;
  logic [4:0]  rs1_no, rs2_no;
  logic        rs1_used, rs2_used;
  logic [31:0] rs1_val, rs2_val, csr_rval, reg10_val;
  logic [11:0] csr_rno;
  logic        issue_valid, issue_wr_reg;
  logic [4:0]  issue_wregno;
  logic        stall_de, sb_overflow, sb_underflow;
  logic [50:0] bus;

  assign bus = {wr_reg, wregno, regval, wcsrno, wr_csr};

  de_regfile_scoreboard dut (
    .clk          (clk),
    .reset        (reset),
    .from_WB_to_DE(bus),
    .rs1_no       (rs1_no),
    .rs2_no       (rs2_no),
    .rs1_used     (rs1_used),
    .rs2_used     (rs2_used),
    .rs1_val      (rs1_val),
    .rs2_val      (rs2_val),
    .csr_rno      (csr_rno),
    .csr_rval     (csr_rval),
    .issue_valid  (issue_valid),
    .issue_wr_reg (issue_wr_reg),
    .issue_wregno (issue_wregno),
    .stall_de     (stall_de),
    .sb_overflow  (sb_overflow),
    .sb_underflow (sb_underflow),
    .reg10_val    (reg10_val)
  );

  always #5 clk = ~clk;

  // Behavioural model
  logic [31:0] m_regs [32];
  logic [31:0] m_csr  [4];
  int          m_cnt  [32];
  bit          m_ovf, m_udf;

  typedef struct {
    logic [31:0] rs1, rs2, csr, r10;
    logic        stall, ovf, udf;
  } exp_t;
  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  function automatic int csr_slot(input logic [11:0] a);
    case (a)
      12'h300: return 0;
      12'h305: return 1;
      12'h341: return 2;
      12'h342: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 0;
      m_cnt[i]  = 0;
    end
    for (int i = 0; i < 4; i++) m_csr[i] = 0;
    m_ovf = 0;
    m_udf = 0;
  endfunction

  function automatic logic [31:0] rd_model(input logic [4:0] r, input bit we);
    if (r == 0) return 0;
    if (we && wregno == r) return regval;
    return m_regs[r];
  endfunction

  function automatic bit busy_model(input logic [4:0] r, input bit we);
    if (r == 0) return 0;
    if (m_cnt[r] >= 2) return 1;
    return (m_cnt[r] == 1) && !(we && wregno == r);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic clear_stim();
    wr_reg = 0; wregno = 0; regval = 0; wcsrno = 0; wr_csr = 0;
    rs1_no = 0; rs2_no = 0; rs1_used = 0; rs2_used = 0; csr_rno = 0;
    issue_valid = 0; issue_wr_reg = 0; issue_wregno = 0;
  endtask

  // One cycle: predict outputs for the current inputs, queue them, then
  // advance the model across the clock edge.
  task automatic step();
    exp_t e;
    bit   we, inc;
    int   s;
    we = wr_reg && (wregno != 0);
    e.rs1 = rd_model(rs1_no, we);
    e.rs2 = rd_model(rs2_no, we);
    s = csr_slot(csr_rno);
    if (s < 0) e.csr = 0;
    else if (wr_csr && wcsrno == csr_rno) e.csr = regval;
    else e.csr = m_csr[s];
    e.r10   = m_regs[10];
    e.stall = (rs1_used && busy_model(rs1_no, we)) || (rs2_used && busy_model(rs2_no, we));
    e.ovf   = m_ovf;
    e.udf   = m_udf;
    if (e.stall) issue_valid = 0;
    exp_q.push_back(e);
    inc = issue_valid && issue_wr_reg && (issue_wregno != 0);
    @(posedge clk);
    if (!(inc && we && issue_wregno == wregno)) begin
      if (inc) begin
        if (m_cnt[issue_wregno] == 3) m_ovf = 1;
        else m_cnt[issue_wregno]++;
      end
      if (we) begin
        if (m_cnt[wregno] == 0) m_udf = 1;
        else m_cnt[wregno]--;
      end
    end
    if (we) m_regs[wregno] = regval;
    s = csr_slot(wcsrno);
    if (wr_csr && s >= 0) m_csr[s] = regval;
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    model_clear();
    @(posedge clk);
    #1 reset = 0;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("rs1_val", rs1_val, e.rs1);
      check("rs2_val", rs2_val, e.rs2);
      check("csr_rval", csr_rval, e.csr);
      check("reg10_val", reg10_val, e.r10);
      check("stall_de", {31'b0, stall_de}, {31'b0, e.stall});
      check("sb_overflow", {31'b0, sb_overflow}, {31'b0, e.ovf});
      check("sb_underflow", {31'b0, sb_underflow}, {31'b0, e.udf});
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    clear_stim();
    reset = 1;
    model_clear();
    repeat (2) @(posedge clk);
    #1 reset = 0;

    // Reset state
    rs1_no = 5; csr_rno = 12'h300; step();

    // Single pending write to x7, resolved by bypass
    clear_stim(); issue_valid = 1; issue_wr_reg = 1; issue_wregno = 7; step();
    clear_stim(); rs1_no = 7; rs1_used = 1; step();
    wr_reg = 1; wregno = 7; regval = 32'hDEADBEEF; step();
    wr_reg = 0; step();

    // Two pending writers on x3
    clear_stim(); issue_valid = 1; issue_wr_reg = 1; issue_wregno = 3; step(); step();
    clear_stim(); rs2_no = 3; rs2_used = 1;
    wr_reg = 1; wregno = 3; regval = 32'h11; step();
    regval = 32'h22; step();
    wr_reg = 0; step();

    // x0 write ignored
    clear_stim(); wr_reg = 1; wregno = 0; regval = 32'hFF; rs1_no = 0; rs1_used = 1; step();
    wr_reg = 0; step();

    // Overflow on x4, underflow on x9
    clear_stim(); issue_valid = 1; issue_wr_reg = 1; issue_wregno = 4;
    repeat (4) step();
    clear_stim(); rs1_no = 4; rs1_used = 1; step();
    clear_stim(); wr_reg = 1; wregno = 9; regval = 32'h99; step();
    clear_stim(); step();

    // x10 and CSR
    clear_stim(); wr_reg = 1; wregno = 10; regval = 32'hFF; step();
    clear_stim(); wr_csr = 1; wcsrno = 12'h341; regval = 32'h80; csr_rno = 12'h341; step();
    clear_stim(); csr_rno = 12'h341; step();
    csr_rno = 12'h123; step();

    // Randomized traffic with a reset partway through
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      int pick;
      if (n == 1500) do_reset();
      wr_reg       = ($urandom_range(0, 1) == 1);
      wregno       = 5'($urandom_range(0, 7));
      regval       = $urandom;
      wr_csr       = ($urandom_range(0, 3) == 0);
      pick         = $urandom_range(0, 4);
      wcsrno       = (pick == 0) ? 12'h300 : (pick == 1) ? 12'h305 :
                     (pick == 2) ? 12'h341 : (pick == 3) ? 12'h342 : 12'($urandom);
      pick         = $urandom_range(0, 4);
      csr_rno      = (pick == 0) ? 12'h300 : (pick == 1) ? 12'h305 :
                     (pick == 2) ? 12'h341 : (pick == 3) ? 12'h342 : 12'($urandom);
      rs1_no       = 5'($urandom_range(0, 7));
      rs2_no       = 5'($urandom_range(0, 10));
      rs1_used     = ($urandom_range(0, 1) == 1);
      rs2_used     = ($urandom_range(0, 1) == 1);
      issue_valid  = ($urandom_range(0, 2) == 0);
      issue_wr_reg = ($urandom_range(0, 3) != 0);
      issue_wregno = 5'($urandom_range(0, 7));
      step();
    end

    clear_stim();
    step();
    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
